// File: rtl/word_array_access_ctrl_if.sv
// Bus bundle between two requesters, the access controller and the word array.
// Ports (as seen by the controller through the slave modport):
//   req_valid/req_we/req_addr/req_wdata  in   per-requester request, packed req 1 above req 0
//   req_ready                            out  one-hot accept, combinational
//   rsp_valid/rsp_rdata                  out  completion pulse and read data
//   mem_sel/mem_rw/mem_din               out  one-hot word select, RW strobe, shared write data
//   mem_dout                             in   read data of the selected word
//   busy                                 out  controller not idle
interface word_array_access_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [DEPTH-1:0]    mem_sel;
  logic                mem_rw;
  logic [DATA_W-1:0]   mem_din;
  logic [DATA_W-1:0]   mem_dout;
  logic                busy;

  // Environment side: requesters plus the word array
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, mem_sel, mem_rw, mem_din, busy
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, mem_sel, mem_rw, mem_din, busy
  );
endinterface

// File: rtl/word_array_access_ctrl.sv
// Access controller for a bank of 2**ADDR_W words shared by two requesters.
// Round-robin arbitration, one access in flight; each access runs
// IDLE -> SETUP -> ACCESS -> RESP so select/data settle before the RW strobe.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high
//   bus   slave modport of word_array_access_ctrl_if (requests, responses, array drive)
module word_array_access_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  word_array_access_ctrl_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state, state_d;
  logic                last_grant, last_grant_d;
  logic                owner, owner_d;
  logic                op_we, op_we_d;
  logic [DEPTH-1:0]    sel_q, sel_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rsp_q, rsp_d;
  logic                busy_q, busy_d;
  logic [1:0]          ready;

  logic                win;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_we;

  // Round-robin pick; a lone requester always wins
  always_comb begin
    win = 1'b0;
    case (bus.req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
    win_addr  = win ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    win_wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    win_we    = bus.req_we[win];
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    owner_d      = owner;
    op_we_d      = op_we;
    sel_d        = sel_q;
    rw_d         = 1'b0;
    din_d        = din_q;
    rdata_d      = rdata_q;
    rsp_d        = 2'b00;
    ready        = 2'b00;

    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          ready        = rst ? 2'b00 : (2'b01 << win);
          state_d      = SETUP;
          owner_d      = win;
          op_we_d      = win_we;
          last_grant_d = win;
          sel_d        = DEPTH'(1) << win_addr;
          din_d        = win_we ? win_wdata : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        rw_d    = op_we;
      end
      ACCESS: begin
        state_d = RESP;
        sel_d   = '0;
        din_d   = '0;
        rsp_d   = 2'b01 << owner;
        if (!op_we) rdata_d = bus.mem_dout;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_we      <= 1'b0;
      sel_q      <= '0;
      rw_q       <= 1'b0;
      din_q      <= '0;
      rdata_q    <= '0;
      rsp_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      owner      <= owner_d;
      op_we      <= op_we_d;
      sel_q      <= sel_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
      rdata_q    <= rdata_d;
      rsp_q      <= rsp_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_sel   = sel_q;
  // Strobe is dropped in a reset cycle so an aborted write never reaches the cells
  assign bus.mem_rw    = rw_q & ~rst;
  assign bus.mem_din   = din_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_word_array_access_ctrl.sv
// Self-checking bench for word_array_access_ctrl: directed steps followed by
// randomized requests, checked against a transaction-level model (reference
// memory, round-robin winner, fixed per-cycle response timeline).
module tb_word_array_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;
  bit   chk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  word_array_access_ctrl_if bus ();

  word_array_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Word array: write while strobed, read mux by select
  logic [7:0] arr [16];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) arr[i] <= 8'(i * 7 + 1);
    end else if (bus.mem_rw) begin
      for (int i = 0; i < 16; i++) if (bus.mem_sel[i]) arr[i] <= bus.mem_din;
    end
  end

  always_comb begin
    bus.mem_dout = 8'h00;
    for (int i = 0; i < 16; i++) if (bus.mem_sel[i]) bus.mem_dout = arr[i];
  end

  // Reference model state
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rdata = 8'h00;
  logic       model_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Array safety properties, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel_onehot0", 32'($countones(bus.mem_sel) <= 1), 32'd1);
      check("rw_without_sel", 32'(bus.mem_rw && (bus.mem_sel == 16'h0)), 32'd0);
    end
  end

  // One request cycle from IDLE through RESP; ends one cycle after RESP
  task automatic op(input logic [1:0] valid, input logic [1:0] we,
                    input logic [3:0] a0, input logic [3:0] a1,
                    input logic [7:0] d0, input logic [7:0] d1,
                    input bit hold, input bit pulse_busy);
    int k;
    logic [3:0] a;
    logic [7:0] d;
    logic w;
    logic [15:0] sel;
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    if (valid == 2'b11) k = model_last ? 0 : 1;
    else                k = valid[1] ? 1 : 0;
    a   = (k == 1) ? a1 : a0;
    d   = (k == 1) ? d1 : d0;
    w   = we[k];
    sel = 16'(1) << a;
    @(negedge clk);
    check("accept_ready", 32'(bus.req_ready), 32'(2'b01 << k));
    check("accept_busy", 32'(bus.busy), 32'd0);
    model_last = k[0];
    @(posedge clk); #1;
    if (!hold) begin
      bus.req_valid = pulse_busy ? 2'b01 : 2'b00;
      bus.req_we    = 2'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = 16'($urandom);
    end
    @(negedge clk);
    check("setup_sel", 32'(bus.mem_sel), 32'(sel));
    check("setup_rw", 32'(bus.mem_rw), 32'd0);
    check("setup_din", 32'(bus.mem_din), 32'(w ? d : 8'h00));
    check("setup_ready", 32'(bus.req_ready), 32'd0);
    check("setup_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    if (pulse_busy && !hold) bus.req_valid = 2'b00;
    @(negedge clk);
    check("access_sel", 32'(bus.mem_sel), 32'(sel));
    check("access_rw", 32'(bus.mem_rw), 32'(w));
    check("access_ready", 32'(bus.req_ready), 32'd0);
    check("access_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    if (w) ref_mem[a] = d;
    else   exp_rdata = ref_mem[a];
    check("resp_sel", 32'(bus.mem_sel), 32'd0);
    check("resp_rw", 32'(bus.mem_rw), 32'd0);
    check("resp_valid", 32'(bus.rsp_valid), 32'(2'b01 << k));
    check("resp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
    check("resp_ready", 32'(bus.req_ready), 32'd0);
    check("array_word", 32'(arr[a]), 32'(ref_mem[a]));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 7 + 1);
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 16'h0000;

    // Reset with both requesters asserting
    @(negedge clk);
    check("rst_ready0", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_sel", 32'(bus.mem_sel), 32'd0);
    check("rst_rw", 32'(bus.mem_rw), 32'd0);
    check("rst_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_din", 32'(bus.mem_din), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_mem = 1'b0;
    bus.req_valid = 2'b00;
    chk_en = 1'b1;

    // Requester 0 write then read of addr 3
    op(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 1'b0, 1'b0);
    op(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Both held valid, reads: grants alternate, accepts 4 cycles apart
    for (int i = 0; i < 4; i++)
      op(2'b11, 2'b00, 4'(i), 4'(i + 8), 8'h00, 8'h00, 1'b1, 1'b0);
    bus.req_valid = 2'b00;

    // Requester 1 write to the top address
    op(2'b10, 2'b10, 4'd0, 4'd15, 8'h00, 8'h3C, 1'b0, 1'b0);
    op(2'b10, 2'b00, 4'd0, 4'd15, 8'h00, 8'h00, 1'b0, 1'b0);

    // Request pulse while busy is ignored
    op(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("idle_after_pulse_busy", 32'(bus.busy), 32'd0);
    check("idle_after_pulse_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a write
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b01;
    bus.req_addr  = 8'h05;
    bus.req_wdata = 16'h0077;
    @(negedge clk);
    check("abort_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rw_gated", 32'(bus.mem_rw), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    check("abort_sel", 32'(bus.mem_sel), 32'd0);
    check("abort_rw", 32'(bus.mem_rw), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    check("abort_rdata", 32'(bus.rsp_rdata), 32'd0);
    exp_rdata = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rsp_late", 32'(bus.rsp_valid), 32'd0);
    check("abort_word", 32'(arr[5]), 32'(ref_mem[5]));
    @(posedge clk); #1;

    // After reset a tie goes to requester 0
    op(2'b11, 2'b00, 4'd5, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++)
      op(2'($urandom_range(1, 3)), 2'($urandom), 4'($urandom), 4'($urandom),
         8'($urandom), 8'($urandom), 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
